// File: rtl/serial_pkg.sv
// Shared definitions for the serial transceiver: receiver FSM encoding,
// frame constants and line levels.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// With SERIAL_RX_MAJORITY_EN the first stage is also exported as a one-cycle look-ahead.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
`ifdef SERIAL_RX_MAJORITY_EN
  output logic o_q_early,
`endif
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make each stage take the other's pre-edge value.
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

`ifdef SERIAL_RX_MAJORITY_EN
  // What o_q will show one cycle from now.
  assign o_q_early = r_meta;
`endif

endmodule

// File: rtl/serial_receiver.sv
// Oversampling 8N1 serial receiver: synchronizes din, frames bytes, pulses rx_status/frame_err.
// SERIAL_RX_MAJORITY_EN: 3-point majority vote at each sample point (needs CLKS_PER_BIT >= 6).
module serial_receiver
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_status,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic w_din_s;
  logic w_fall;
  logic w_sample;

  rx_state_e            r_state,   w_state_nxt;
  logic [CNT_W-1:0]     r_cnt,     w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx,     w_idx_nxt;
  logic [DATA_BITS-1:0] r_shreg,   w_shreg_nxt;
  logic [DATA_BITS-1:0] r_rx_data, w_rx_data_nxt;
  logic                 r_status,  w_status_nxt;
  logic                 r_ferr,    w_ferr_nxt;
  logic                 r_din_prev;

`ifdef SERIAL_RX_MAJORITY_EN
  logic w_din_early;

  bit_sync #(.RESET_VAL(LINE_IDLE)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .i_d       (din),
    .o_q_early (w_din_early),
    .o_q       (w_din_s)
  );

  // Neighbours of the nominal point: previous din_s and next-cycle din_s.
  assign w_sample = majority3(r_din_prev, w_din_s, w_din_early);
`else
  bit_sync #(.RESET_VAL(LINE_IDLE)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (din),
    .o_q (w_din_s)
  );

  assign w_sample = w_din_s;
`endif

  // A line stuck low never produces a second start.
  assign w_fall = (r_din_prev == LINE_IDLE) && (w_din_s == LINE_START);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_idx_nxt     = r_idx;
    w_shreg_nxt   = r_shreg;
    w_rx_data_nxt = r_rx_data;
    w_status_nxt  = 1'b0;
    w_ferr_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt = '0;
          if (w_sample == LINE_START) begin
            w_state_nxt = ST_DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shreg_nxt = {w_sample, r_shreg[DATA_BITS-1:1]};
          if (r_idx == IDX_LAST) w_state_nxt = ST_STOP;
          else                   w_idx_nxt   = r_idx + 1'b1;
        end
      end
      ST_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
          if (w_sample == LINE_IDLE) begin
            w_rx_data_nxt = r_shreg;
            w_status_nxt  = 1'b1;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shreg    <= '0;
      r_rx_data  <= '0;
      r_status   <= 1'b0;
      r_ferr     <= 1'b0;
      r_din_prev <= LINE_IDLE;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_shreg    <= w_shreg_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_status   <= w_status_nxt;
      r_ferr     <= w_ferr_nxt;
      r_din_prev <= w_din_s;
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_status = r_status;
  assign frame_err = r_ferr;
  assign rx_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver at 16 clk/bit; expected values are hand-computed.
module tb_serial_receiver;

  localparam int CPB = 16;
  localparam int LAT = 154;  // first low sample edge -> cycle with the pulse
  localparam int GAP = 160;  // 10 bit times between back-to-back frames

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       frame_err;
  logic       rx_busy;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int n_status, n_ferr, n_overlap, n_busy;
  int last_status_cyc, prev_status_cyc, last_ferr_cyc;
  int last_start;
  int first_cyc;

  serial_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_status) begin
      n_status++;
      prev_status_cyc = last_status_cyc;
      last_status_cyc = cyc;
    end
    if (frame_err) begin
      n_ferr++;
      last_ferr_cyc = cyc;
    end
    if (rx_status && frame_err) n_overlap++;
    if (rx_busy) n_busy++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_status = 0;
    n_ferr   = 0;
    n_busy   = 0;
  endtask

  // Entered and left just after a posedge; holds lvl for n sampling edges.
  task automatic hold(input logic lvl, input int n);
    din = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    last_start = cyc + 1;
    for (int i = 0; i < 10; i++) hold(bits[i], CPB);
    din = 1'b1;
  endtask

`ifdef SERIAL_RX_MAJORITY_EN
  // Inverts din for the single edge at the nominal sample point of data bit k.
  task automatic send_glitched(input logic [7:0] b, input int k);
    last_start = cyc + 1;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == k) begin
        hold(b[i], CPB / 2);
        hold(~b[i], 1);
        hold(b[i], CPB / 2 - 1);
      end else begin
        hold(b[i], CPB);
      end
    end
    hold(1'b1, CPB);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_overlap = 0;
    last_status_cyc = 0;
    prev_status_cyc = 0;
    last_ferr_cyc = 0;
    clear_counts();

    rst = 1'b1;
    din = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_status", rx_status, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_rx_busy", rx_busy, 1'b0);
    rst = 1'b0;
    hold(1'b1, 10);

    // Single good frame and its latency.
    clear_counts();
    send_frame(8'hA5, 1'b1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_status_count", n_status, 1);
    check("a5_ferr_count", n_ferr, 0);
    check("a5_latency", last_status_cyc - last_start, LAT);
    check("a5_busy_after", rx_busy, 1'b0);

    // Back-to-back frames with a single stop bit.
    clear_counts();
    send_frame(8'h00, 1'b1);
    first_cyc = last_status_cyc;
    check("b2b_first_data", rx_data, 8'h00);
    send_frame(8'hFF, 1'b1);
    check("b2b_second_data", rx_data, 8'hFF);
    check("b2b_status_count", n_status, 2);
    check("b2b_spacing", last_status_cyc - first_cyc, GAP);
    hold(1'b1, 10);

    // Short low glitch: start rejected after H cycles.
    clear_counts();
    hold(1'b0, 3);
    hold(1'b1, 40);
    check("glitch_status_count", n_status, 0);
    check("glitch_ferr_count", n_ferr, 0);
    check("glitch_busy_cycles", n_busy, CPB / 2);

    // Framing error keeps the previous byte.
    send_frame(8'h12, 1'b1);
    check("pre_ferr_data", rx_data, 8'h12);
    clear_counts();
    send_frame(8'h55, 1'b0);
    hold(1'b1, 20);
    check("ferr_count", n_ferr, 1);
    check("ferr_status_count", n_status, 0);
    check("ferr_data_held", rx_data, 8'h12);
    check("ferr_latency", last_ferr_cyc - last_start, LAT);

    // Break: one framing error only, then recovery.
    clear_counts();
    hold(1'b0, 20 * CPB);
    hold(1'b1, 20);
    check("break_ferr_count", n_ferr, 1);
    check("break_status_count", n_status, 0);
    check("break_data_held", rx_data, 8'h12);
    clear_counts();
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 10);
    check("post_break_data", rx_data, 8'h3C);
    check("post_break_status_count", n_status, 1);

    // Reset during data bit 4 of a 0x5A frame.
    clear_counts();
    hold(1'b0, CPB);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b1, CPB / 2);
    check("pre_rst_busy", rx_busy, 1'b1);
    rst = 1'b1;
    din = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_status", rx_status, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    check("midrst_rx_busy", rx_busy, 1'b0);
    rst = 1'b0;
    hold(1'b1, 3 * GAP);
    check("midrst_no_pulses", n_status + n_ferr, 0);
    send_frame(8'hC3, 1'b1);
    hold(1'b1, 10);
    check("post_rst_data", rx_data, 8'hC3);
    check("post_rst_status_count", n_status, 1);

`ifdef SERIAL_RX_MAJORITY_EN
    clear_counts();
    send_glitched(8'hA5, 3);
    check("majority_data", rx_data, 8'hA5);
    check("majority_status_count", n_status, 1);
    check("majority_latency", last_status_cyc - last_start, LAT);
`endif

    check("pulse_overlap", n_overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- Receive side of the serial transceiver. Consumes the sender's line output: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), line idle high.
- Oversamples the line on the system clock, recovers each byte, and presents it with a one-cycle valid pulse plus a framing-error pulse.
- Sits between the external line pin and the byte consumer/status logic.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per bit time. Must be ≥4. H = CLKS_PER_BIT/2, rounded down.
- DATA_BITS, 8: data bits per frame. Fixed by the frame format; not to be overridden.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- din  in  1  serial line, asynchronous to clk, idle high.
- rx_data  out  8  last correctly framed byte; held until the next good frame.
- rx_status  out  1  one-cycle pulse: rx_data has just been updated.
- frame_err  out  1  one-cycle pulse: stop bit was sampled 0.
- rx_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values:
  - Synchronizer flops = 1; edge-history flop = 1.
  - rx_data = 0; rx_status = 0; frame_err = 0; rx_busy = 0.
  - FSM = IDLE; bit counter and cycle counter = 0.
- Synchronizer: din passes through 2 flops (din_s). A third flop holds the previous din_s for edge detection.
- Start detect: only a 1→0 transition of din_s. A constant low never re-arms the receiver.
- Cycle counter width is $clog2(CLKS_PER_BIT). It clears on every state entry.
- Let T = the edge on which IDLE detects the falling edge.
- IDLE:
  - On a falling edge, go to START and clear the counter.
- START:
  - At counter == H-1 (edge T+H), sample din_s.
  - If 0, go to DATA with bit index 0.
  - If 1, treat as a glitch: return to IDLE with no pulse.
- DATA:
  - At counter == CLKS_PER_BIT-1, sample din_s. Samples fall on edges T+H+k·CLKS_PER_BIT, k = 1..8.
  - Shift as shreg <= {sample, shreg[7:1]} (LSB arrives first).
  - After the 8th sample, go to STOP.
- STOP:
  - Sample at edge T+H+9·CLKS_PER_BIT.
  - If 1: rx_data <= shreg and rx_status = 1 for the next cycle only.
  - If 0: frame_err = 1 for one cycle; rx_data is unchanged.
  - In both cases go to IDLE on that same edge. This allows back-to-back frames with a single stop bit.
- Latency: rx_status (or frame_err) is high in the cycle after edge T+H+9·CLKS_PER_BIT. T is 2 edges after din is first sampled low. With CLKS_PER_BIT = 16 the total is 2+8+144 = 154 edges.
- Pulse exclusivity: rx_status and frame_err are never high together. Each is high for exactly one cycle per frame.
- Break condition (line held low): produces one frame_err. No further activity until the line returns high and falls again.
- Reset mid-frame: takes priority over all state activity. All outputs return to their reset values on the next edge, and the partial frame is discarded.
- rx_data holds indefinitely. There is no overrun detection; an unread byte is overwritten by the next good frame.

Optional Feature:
- Macro: SERIAL_RX_MAJORITY_EN.
- Defined: each sample point (start, data, stop) takes the majority of din_s at counter values C-1, C and C+1 around the nominal point C. Timing of state transitions and pulses is unchanged. Requires CLKS_PER_BIT ≥ 6.
- Undefined: single sample at the nominal point C.

Decomposition:
- Package serial_pkg contains:
  - the FSM state encoding (IDLE, START, DATA, STOP);
  - the DATA_BITS = 8 constant;
  - the line idle level (1) and start level (0).
- The sender shares serial_pkg.
- One sub-module: bit_sync, a 2-flop synchronizer with a reset value parameter (1 here).
- All other logic stays in one FSM module.

Test Plan:
- Frame 0xA5 at 16 clk/bit → rx_data = 0xA5; rx_status high for exactly 1 cycle, 154 edges after the first low sample; frame_err stays 0.
- Back-to-back 0x00 then 0xFF with one stop bit each → two rx_status pulses exactly 160 cycles apart; rx_data reads 0x00 then 0xFF.
- din low for 3 cycles, then high → no pulses; rx_busy high for H cycles, then 0.
- Frame 0x55 with stop bit forced 0, after a prior good 0x12 → frame_err pulses once; rx_data stays 0x12.
- din held low for 20 bit times → exactly one frame_err. After din goes high, a frame 0x3C is received correctly.
- rst asserted for 1 cycle during data bit 4, then a frame 0xC3 → all outputs 0 after the reset edge; 0xC3 is received correctly. With SERIAL_RX_MAJORITY_EN, add a 1-cycle inverted glitch at a nominal sample point: the data is still correct.
